// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan sequencer, the 256:1 mux it drives, the word source and the byte sink.
// slave is the sequencer's view; master is the surrounding system (source, sink and mux).
interface mux_scan_ctrl_if #(
  parameter int WIDTH = 256,
  parameter int SEL_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] mux_data;
  logic [SEL_W-1:0] sel;
  logic             mux_bit;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  in_valid, a_in, byte_ready, mux_bit,
    output in_ready, mux_data, sel, byte_out, byte_valid, busy, done
  );

  modport master (
    output in_valid, a_in, byte_ready, mux_bit,
    input  in_ready, mux_data, sel, byte_out, byte_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sweeps the external mux select over a held word, samples its output bit and
// repacks the bits LSB-first into bytes behind a one-byte output buffer.
module mux_scan_ctrl #(
  parameter int WIDTH = 256,
  parameter int SEL_W = 8
) (
  input logic           clk,
  input logic           rst,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] sel_reg;
  logic [WIDTH-1:0] mux_data_reg;
  logic [6:0]       shreg_reg, shreg_next;
  logic [7:0]       byte_reg;
  logic             byte_valid_reg;

  logic [2:0] bit_idx;
  logic       accept, sample, byte_load, last_sample, byte_take;

  assign bit_idx     = sel_reg[2:0];
  assign accept      = (state_reg == IDLE) && bus.in_valid;
  assign byte_take   = byte_valid_reg && bus.byte_ready;
  // The byte-completing bit may only be taken when the buffer is empty or emptying now.
  assign sample      = (state_reg == SCAN) &&
                       ((bit_idx != 3'd7) || !byte_valid_reg || bus.byte_ready);
  assign byte_load   = sample && (bit_idx == 3'd7);
  assign last_sample = sample && (sel_reg == SEL_W'(WIDTH - 1));

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_shreg
      assign shreg_next[gi] = (sample && (bit_idx == 3'(gi))) ? bus.mux_bit : shreg_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)      state_next = SCAN;
      SCAN:    if (last_sample) state_next = DRAIN;
      DRAIN:   if (byte_take)   state_next = DONE;
      DONE:                     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_reg)
      IDLE:    bus.in_ready = 1'b1;
      SCAN:    bus.busy     = 1'b1;
      DRAIN:   bus.busy     = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg        <= '0;
      mux_data_reg   <= '0;
      shreg_reg      <= '0;
      byte_reg       <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      shreg_reg <= shreg_next;
      if (accept) begin
        mux_data_reg <= bus.a_in;
        sel_reg      <= '0;
      end else if (last_sample) begin
        sel_reg <= '0;
      end else if (sample) begin
        sel_reg <= sel_reg + SEL_W'(1);
      end
      // A fresh byte overrides the clear from a same-cycle handoff.
      if (byte_load) begin
        byte_reg       <= {bus.mux_bit, shreg_reg};
        byte_valid_reg <= 1'b1;
      end else if (byte_take) begin
        byte_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.sel        = sel_reg;
  assign bus.mux_data   = mux_data_reg;
  assign bus.byte_out   = byte_reg;
  assign bus.byte_valid = byte_valid_reg;

endmodule
